// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Brief    : Shared widths, select encodings and helpers for demux_1to4_stream
// Revision : 1.0 - initial release
// ============================================================================
package demux_pkg;

  localparam int DATA_W = 24;
  localparam int SEL_W  = 2;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  localparam logic [SEL_W-1:0] SEL_A = 2'b00;
  localparam logic [SEL_W-1:0] SEL_B = 2'b01;
  localparam logic [SEL_W-1:0] SEL_C = 2'b10;
  localparam logic [SEL_W-1:0] SEL_D = 2'b11;

  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] one;
    one = {{(NUM_CH-1){1'b0}}, 1'b1};
    return one << sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// ============================================================================
// Module   : demux_slot
// Brief    : One-entry holding register with fill/drain handshake
// Revision : 1.0 - initial release
// ============================================================================
module demux_slot #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_fill,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_full,
  output logic [DATA_W-1:0] o_data
);

  logic              r_full;
  logic [DATA_W-1:0] r_data;
  logic              w_drain;

  assign w_drain = r_full & i_ready;

  // A fill in the same cycle as a drain wins, keeping the slot full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else begin
      if (i_fill) begin
        r_full <= 1'b1;
        r_data <= i_data;
      end else if (w_drain) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/demux_1to4_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux_1to4_stream
// Brief    : Registered 1-to-4 stream demux, one holding slot per channel.
//            Optional macro DEMUX_STATS_EN adds saturating drain counters.
// Revision : 1.0 - initial release
// ============================================================================
module demux_1to4_stream
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [DATA_W-1:0] out_data_a,
  output logic [DATA_W-1:0] out_data_b,
  output logic [DATA_W-1:0] out_data_c,
  output logic [DATA_W-1:0] out_data_d
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt_a,
  output logic [CNT_W-1:0]  cnt_b,
  output logic [CNT_W-1:0]  cnt_c,
  output logic [CNT_W-1:0]  cnt_d
`endif
);

  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_sel_oh;
  logic [NUM_CH-1:0] w_fill;
  logic [DATA_W-1:0] w_slot_data [NUM_CH];

  // Ready looks only at the addressed channel so other stalls never block it.
  assign in_ready = ~w_full[in_sel] | out_ready[in_sel];
  assign w_sel_oh = sel_onehot(in_sel);
  assign w_fill   = w_sel_oh & {NUM_CH{in_valid & in_ready}};

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
      demux_slot #(
        .DATA_W (DATA_W)
      ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_fill  (w_fill[i]),
        .i_data  (in_data),
        .i_ready (out_ready[i]),
        .o_full  (w_full[i]),
        .o_data  (w_slot_data[i])
      );
    end
  endgenerate

  assign out_valid  = w_full;
  assign out_data_a = w_slot_data[SEL_A];
  assign out_data_b = w_slot_data[SEL_B];
  assign out_data_c = w_slot_data[SEL_C];
  assign out_data_d = w_slot_data[SEL_D];

`ifdef DEMUX_STATS_EN
  logic [NUM_CH-1:0] w_fire;
  logic [CNT_W-1:0]  r_cnt [NUM_CH];

  assign w_fire = w_full & out_ready;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_cnt[i] <= '0;
        end else if (w_fire[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  endgenerate

  assign cnt_a = r_cnt[SEL_A];
  assign cnt_b = r_cnt[SEL_B];
  assign cnt_c = r_cnt[SEL_C];
  assign cnt_d = r_cnt[SEL_D];
`endif

endmodule
`default_nettype wire
